// File: rtl/azimuth_frame_loader_pkg.sv
// Shared definitions for the azimuth frame loader: stream width, default
// geometry, loader state encoding and the frame-size helper.
package az_sim_pkg;

  localparam int AXIS_W           = 32;
  localparam int DEFAULT_SIZE     = 3200;
  localparam int DEFAULT_AZ_COUNT = 4096;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } loader_state_e;

  // Number of stream words needed to carry one frame of `size` bits.
  function automatic int words_of(input int size);
    return size / AXIS_W;
  endfunction

endpackage

// File: rtl/azimuth_frame_loader_if.sv
// Valid/ready word stream from the DMA FIFO into the frame loader.
interface azimuth_frame_loader_if;
  import az_sim_pkg::*;

  logic [AXIS_W-1:0] S_TDATA;
  logic              S_TVALID;
  logic              S_TREADY;

  modport master (output S_TDATA, output S_TVALID, input  S_TREADY);
  modport slave  (input  S_TDATA, input  S_TVALID, output S_TREADY);

endinterface

// File: rtl/azimuth_frame_loader_shadow_buffer.sv
// Shadow frame buffer: one indexed 32-bit word write per cycle into a
// SIZE-bit register, plus a flag that marks the frame complete.
// data_o is write-through: it already contains the word written this cycle,
// so a swap on the final word sees the whole frame.
module az_shadow_buffer
  import az_sim_pkg::*;
#(
  parameter int SIZE  = DEFAULT_SIZE,
  parameter int CNT_W = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  idx_i,
  input  logic [AXIS_W-1:0] wdata_i,
  input  logic              take_i,
  output logic [SIZE-1:0]   data_o,
  output logic              full_o
);

  localparam int WORDS = words_of(SIZE);

  logic [SIZE-1:0] data_q, data_d;
  logic            full_q, full_d;

  // Merge the incoming word into its slot and track frame completion.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    data_d = data_q;
    full_d = full_q;
    for (int i = 0; i < WORDS; i++) begin
      if (we_i && idx_i == CNT_W'(i)) begin
        data_d[AXIS_W*i +: AXIS_W] = wdata_i;
      end
    end
    if (we_i && idx_i == CNT_W'(WORDS-1)) full_d = 1'b1;
    if (take_i)                          full_d = 1'b0;
  end

  // Buffer register; the clear discards any partial frame.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is a plain register bank, not a RAM, so it can and must be reset to discard partial frames.
    if (!rst_n || clr_i) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
    end
  end

  assign data_o = data_d;
  assign full_o = full_q;

endmodule

// File: rtl/azimuth_frame_loader.sv
// Azimuth frame loader: assembles per-azimuth frames from a word stream into
// a shadow buffer and swaps them into the generator on each azimuth trigger.
// Optional statistics counters are built when AZ_LOADER_STATS_EN is defined.
module azimuth_frame_loader
  import az_sim_pkg::*;
#(
  parameter int SIZE     = DEFAULT_SIZE,
  parameter int AZ_COUNT = DEFAULT_AZ_COUNT
) (
  input  logic                        SYS_CLK,
  input  logic                        RESETN,
  input  logic                        EN,
  input  logic                        TRIG,
  input  logic                        ARP,
  azimuth_frame_loader_if.slave       s_axis,
  output logic [SIZE-1:0]             DATA,
  output logic [$clog2(AZ_COUNT)-1:0] AZ_IDX,
  output logic                        FRAME_SWAP,
  output logic                        UNDERRUN,
  output logic                        UNDERRUN_STICKY
`ifdef AZ_LOADER_STATS_EN
  ,
  output logic [15:0]                 UNDERRUN_CNT,
  output logic [31:0]                 FRAME_CNT
`endif
);

  localparam int WORDS = words_of(SIZE);
  localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int AZ_W  = $clog2(AZ_COUNT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);
  localparam logic [AZ_W-1:0]  AZ_LAST  = AZ_W'(AZ_COUNT - 1);

  loader_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SIZE-1:0]  data_q, data_d;
  logic [AZ_W-1:0]  az_q, az_d;
  logic             tready_q, tready_d;
  logic             swap_q, swap_d;
  logic             under_q, under_d;
  logic             sticky_q, sticky_d;

  logic             xfer;
  logic             last_xfer;
  logic [SIZE-1:0]  shadow_view;
  logic             shadow_full;

  assign xfer      = s_axis.S_TVALID & tready_q;
  assign last_xfer = xfer && (cnt_q == CNT_LAST);

  az_shadow_buffer #(
    .SIZE  (SIZE),
    .CNT_W (CNT_W)
  ) u_shadow (
    .clk     (SYS_CLK),
    .rst_n   (RESETN),
    .clr_i   (!EN),
    .we_i    (xfer),
    .idx_i   (cnt_q),
    .wdata_i (s_axis.S_TDATA),
    .take_i  (swap_d),
    .data_o  (shadow_view),
    .full_o  (shadow_full)
  );

  // Next state: word counting, trigger service (swap or blank), azimuth index.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    az_d     = az_q;
    swap_d   = 1'b0;
    under_d  = 1'b0;
    sticky_d = sticky_q;

    case (state_q)
      FILL: begin
        if (xfer) begin
          if (last_xfer) begin
            cnt_d   = '0;
            state_d = READY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      READY: ;
      default: state_d = FILL;
    endcase

    if (TRIG) begin
      // A trigger on the final word counts as a complete frame.
      if ((state_q == READY && shadow_full) || last_xfer) begin
        data_d  = shadow_view;
        swap_d  = 1'b1;
        state_d = FILL;
      end else begin
        data_d   = '0;
        under_d  = 1'b1;
        sticky_d = 1'b1;
      end
      az_d = (az_q == AZ_LAST) ? '0 : az_q + 1'b1;
    end

    if (ARP) az_d = '0;

    tready_d = (state_d == FILL);

    if (!EN) begin
      state_d  = FILL;
      cnt_d    = '0;
      data_d   = '0;
      az_d     = '0;
      swap_d   = 1'b0;
      under_d  = 1'b0;
      sticky_d = 1'b0;
      tready_d = 1'b0;
    end
  end

  // Loader state registers with synchronous active-low reset.
  always_ff @(posedge SYS_CLK) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together at the edge.
    if (!RESETN) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      data_q   <= '0;
      az_q     <= '0;
      tready_q <= 1'b0;
      swap_q   <= 1'b0;
      under_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      az_q     <= az_d;
      tready_q <= tready_d;
      swap_q   <= swap_d;
      under_q  <= under_d;
      sticky_q <= sticky_d;
    end
  end

  assign s_axis.S_TREADY = tready_q;
  assign DATA            = data_q;
  assign AZ_IDX          = az_q;
  assign FRAME_SWAP      = swap_q;
  assign UNDERRUN        = under_q;
  assign UNDERRUN_STICKY = sticky_q;

`ifdef AZ_LOADER_STATS_EN
  logic [15:0] ucnt_q, ucnt_d;
  logic [31:0] fcnt_q, fcnt_d;

  // Statistics next state: saturating underrun count, wrapping swap count.
  always_comb begin
    ucnt_d = ucnt_q;
    fcnt_d = fcnt_q;
    if (under_d && ucnt_q != 16'hFFFF) ucnt_d = ucnt_q + 16'd1;
    if (swap_d)                        fcnt_d = fcnt_q + 32'd1;
  end

  // Statistics survive EN low; only reset clears them.
  always_ff @(posedge SYS_CLK) begin
    if (!RESETN) begin
      ucnt_q <= '0;
      fcnt_q <= '0;
    end else begin
      ucnt_q <= ucnt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign UNDERRUN_CNT = ucnt_q;
  assign FRAME_CNT    = fcnt_q;
`else
  // Statistics disabled: no counter hardware and no counter ports.
`endif

endmodule

// File: tb/tb_azimuth_frame_loader.sv
// Directed self-checking bench for azimuth_frame_loader (default geometry:
// 3200-bit frames of 100 words, 4096 azimuth steps).
// Statistics checks are compiled when AZ_LOADER_STATS_EN is defined.
module tb_azimuth_frame_loader;
  import az_sim_pkg::*;

  localparam int SIZE     = DEFAULT_SIZE;
  localparam int AZ_COUNT = DEFAULT_AZ_COUNT;
  localparam int WORDS    = words_of(SIZE);
  localparam int AZ_W     = $clog2(AZ_COUNT);

  logic            SYS_CLK = 1'b0;
  logic            RESETN  = 1'b0;
  logic            EN      = 1'b0;
  logic            TRIG    = 1'b0;
  logic            ARP     = 1'b0;
  logic [SIZE-1:0] DATA;
  logic [AZ_W-1:0] AZ_IDX;
  logic            FRAME_SWAP;
  logic            UNDERRUN;
  logic            UNDERRUN_STICKY;
`ifdef AZ_LOADER_STATS_EN
  logic [15:0]     UNDERRUN_CNT;
  logic [31:0]     FRAME_CNT;
`endif

  int checks = 0;
  int errors = 0;
  logic [SIZE-1:0] exp_data;

  azimuth_frame_loader_if s_if ();

  azimuth_frame_loader #(
    .SIZE     (SIZE),
    .AZ_COUNT (AZ_COUNT)
  ) dut (
    .SYS_CLK         (SYS_CLK),
    .RESETN          (RESETN),
    .EN              (EN),
    .TRIG            (TRIG),
    .ARP             (ARP),
    .s_axis          (s_if),
    .DATA            (DATA),
    .AZ_IDX          (AZ_IDX),
    .FRAME_SWAP      (FRAME_SWAP),
    .UNDERRUN        (UNDERRUN),
    .UNDERRUN_STICKY (UNDERRUN_STICKY)
`ifdef AZ_LOADER_STATS_EN
    ,
    .UNDERRUN_CNT    (UNDERRUN_CNT),
    .FRAME_CNT       (FRAME_CNT)
`endif
  );

  always #5 SYS_CLK = ~SYS_CLK;

  task automatic tick();
    @(posedge SYS_CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_wide(input string tag, input logic [SIZE-1:0] obs, input logic [SIZE-1:0] exp);
    int bad;
    checks++;
    assert (obs === exp) else begin
      errors++;
      bad = 0;
      for (int i = WORDS - 1; i >= 0; i--) begin
        if (obs[32*i +: 32] !== exp[32*i +: 32]) bad = i;
      end
      $error("FAIL %s: word %0d observed %h expected %h", tag, bad,
             obs[32*bad +: 32], exp[32*bad +: 32]);
    end
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    EN = 1'b0;
    TRIG = 1'b0;
    ARP = 1'b0;
    s_if.S_TVALID = 1'b0;
    s_if.S_TDATA = '0;
    tick();
    tick();
    RESETN = 1'b1;
    EN = 1'b1;
    tick();
  endtask

  // One word transfer; waits a bounded time for S_TREADY.
  task automatic send_word(input logic [31:0] w);
    int guard;
    guard = 0;
    s_if.S_TDATA = w;
    s_if.S_TVALID = 1'b1;
    while (s_if.S_TREADY !== 1'b1 && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $error("FAIL tready_timeout: observed S_TREADY=%b expected 1", s_if.S_TREADY);
    end
    tick();
    s_if.S_TVALID = 1'b0;
  endtask

  task automatic pulse_trig();
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
  endtask

  initial begin
    s_if.S_TDATA = '0;
    s_if.S_TVALID = 1'b0;

    // Reset state.
    do_reset();
    RESETN = 1'b0;
    tick();
    check("rst_tready", s_if.S_TREADY, 1'b0);
    check_wide("rst_data", DATA, '0);
    check("rst_az", AZ_IDX, 0);
    check("rst_sticky", UNDERRUN_STICKY, 1'b0);
    check("rst_swap", FRAME_SWAP, 1'b0);
`ifdef AZ_LOADER_STATS_EN
    check("rst_ucnt", UNDERRUN_CNT, 0);
    check("rst_fcnt", FRAME_CNT, 0);
`endif
    RESETN = 1'b1;
    EN = 1'b1;
    tick();
    check("fill_tready", s_if.S_TREADY, 1'b1);

    // Full frame of ones then a trigger.
    for (int k = 0; k < WORDS; k++) send_word(32'hFFFF_FFFF);
    check("ready_tready_low", s_if.S_TREADY, 1'b0);
    pulse_trig();
    check_wide("ones_data", DATA, {SIZE{1'b1}});
    check("ones_swap", FRAME_SWAP, 1'b1);
    check("ones_under", UNDERRUN, 1'b0);
    check("ones_az", AZ_IDX, 1);
    check("ones_tready", s_if.S_TREADY, 1'b1);
    tick();
    check("ones_swap_pulse_end", FRAME_SWAP, 1'b0);

    // Underrun at half frame; the fill then completes normally.
    do_reset();
    exp_data = '0;
    for (int k = 0; k < WORDS / 2; k++) begin
      send_word(32'hA500_0000 | k);
      exp_data[32*k +: 32] = 32'hA500_0000 | k;
    end
    pulse_trig();
    check_wide("under_data", DATA, '0);
    check("under_pulse", UNDERRUN, 1'b1);
    check("under_sticky", UNDERRUN_STICKY, 1'b1);
    check("under_swap", FRAME_SWAP, 1'b0);
    check("under_az", AZ_IDX, 1);
    tick();
    check("under_pulse_end", UNDERRUN, 1'b0);
    check("under_sticky_hold", UNDERRUN_STICKY, 1'b1);
    for (int k = WORDS / 2; k < WORDS; k++) begin
      send_word(32'hA500_0000 | k);
      exp_data[32*k +: 32] = 32'hA500_0000 | k;
    end
    pulse_trig();
    check("resume_swap", FRAME_SWAP, 1'b1);
    check("resume_under", UNDERRUN, 1'b0);
    check_wide("resume_data", DATA, exp_data);
    check("resume_az", AZ_IDX, 2);

    // Trigger coinciding with the final word.
    for (int k = 0; k < WORDS - 1; k++) begin
      send_word(32'h1111_1111);
      exp_data[32*k +: 32] = 32'h1111_1111;
    end
    exp_data[32*(WORDS-1) +: 32] = 32'hDEAD_BEEF;
    s_if.S_TDATA = 32'hDEAD_BEEF;
    s_if.S_TVALID = 1'b1;
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    s_if.S_TVALID = 1'b0;
    check("coinc_swap", FRAME_SWAP, 1'b1);
    check("coinc_under", UNDERRUN, 1'b0);
    check("coinc_top_word", DATA[SIZE-1 -: 32], 32'hDEAD_BEEF);
    check_wide("coinc_data", DATA, exp_data);
    check("coinc_tready", s_if.S_TREADY, 1'b1);
    check("coinc_az", AZ_IDX, 3);

    // Underrun right after a swap blanks the active frame.
    pulse_trig();
    check_wide("blank_data", DATA, '0);
    check("blank_under", UNDERRUN, 1'b1);
    check("blank_az", AZ_IDX, 4);

    // Azimuth index wrap and ARP handling.
    do_reset();
    TRIG = 1'b1;
    for (int k = 0; k < AZ_COUNT - 1; k++) tick();
    check("az_top", AZ_IDX, AZ_COUNT - 1);
    tick();
    check("az_wrap", AZ_IDX, 0);
    for (int k = 0; k < 10; k++) tick();
    check("az_ten", AZ_IDX, 10);
    ARP = 1'b1;
    tick();
    ARP = 1'b0;
    TRIG = 1'b0;
    check("arp_trig_az", AZ_IDX, 0);
    check("arp_trig_serviced", UNDERRUN, 1'b1);
    pulse_trig();
    pulse_trig();
    pulse_trig();
    check("az_three", AZ_IDX, 3);
    ARP = 1'b1;
    tick();
    ARP = 1'b0;
    check("arp_alone_az", AZ_IDX, 0);
    check("arp_alone_no_under", UNDERRUN, 1'b0);

    // EN dropped mid-frame discards the partial shadow.
    do_reset();
    for (int k = 0; k < WORDS; k++) send_word(32'h5A5A_0000 | k);
    pulse_trig();
    check("pre_en_swap", FRAME_SWAP, 1'b1);
    for (int k = 0; k < 30; k++) send_word(32'hCAFE_0000 | k);
    EN = 1'b0;
    tick();
    check("en_low_tready", s_if.S_TREADY, 1'b0);
    check_wide("en_low_data", DATA, '0);
    check("en_low_az", AZ_IDX, 0);
    TRIG = 1'b1;
    tick();
    TRIG = 1'b0;
    check("en_low_trig_swap", FRAME_SWAP, 1'b0);
    check("en_low_trig_under", UNDERRUN, 1'b0);
    check("en_low_trig_az", AZ_IDX, 0);
    EN = 1'b1;
    tick();
    check("en_high_tready", s_if.S_TREADY, 1'b1);
    exp_data = '0;
    for (int k = 0; k < WORDS; k++) begin
      send_word(k);
      exp_data[32*k +: 32] = k;
    end
    pulse_trig();
    check("en_frame_swap", FRAME_SWAP, 1'b1);
    check("en_frame_low_word", DATA[31:0], 0);
    check("en_frame_top_word", DATA[SIZE-1 -: 32], WORDS - 1);
    check_wide("en_frame_data", DATA, exp_data);
    check("en_frame_az", AZ_IDX, 1);

`ifdef AZ_LOADER_STATS_EN
    // Statistics: 3 underruns and 5 swaps survive an EN toggle.
    do_reset();
    check("stat_rst_ucnt", UNDERRUN_CNT, 0);
    check("stat_rst_fcnt", FRAME_CNT, 0);
    for (int u = 0; u < 3; u++) pulse_trig();
    check("stat_ucnt_3", UNDERRUN_CNT, 3);
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < WORDS; k++) send_word(f * 1000 + k);
      pulse_trig();
    end
    check("stat_ucnt", UNDERRUN_CNT, 3);
    check("stat_fcnt", FRAME_CNT, 5);
    EN = 1'b0;
    tick();
    tick();
    EN = 1'b1;
    tick();
    check("stat_en_sticky_clr", UNDERRUN_STICKY, 1'b0);
    check("stat_en_ucnt", UNDERRUN_CNT, 3);
    check("stat_en_fcnt", FRAME_CNT, 5);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/azimuth_frame_loader.md
Name: azimuth_frame_loader

Overview:
- Feeds the azimuth signal generator's SIZE-bit DATA word.
- Receives per-azimuth frames as a 32-bit valid/ready word stream from the DMA FIFO and assembles each frame in a shadow buffer.
- On each azimuth trigger pulse, swaps the shadow buffer into the active buffer driven to the generator.
- Tracks the azimuth index and flags underruns when a trigger arrives before the next frame is complete.

Parameters:
- SIZE, 3200, frame width in bits; must be a multiple of 32.
- AZ_COUNT, 4096, azimuth steps per revolution; AZ_IDX wraps at AZ_COUNT-1.
- WORDS, SIZE/32, local constant: stream words per frame.

Ports:
- SYS_CLK  in  1  system clock; all logic on the rising edge.
- RESETN  in  1  synchronous reset, active-low.
- EN  in  1  enable; low behaves as a synchronous clear of all state except the optional counter.
- TRIG  in  1  one-cycle azimuth trigger pulse, already edge-detected.
- ARP  in  1  one-cycle north/revolution pulse, already edge-detected.
- S_TDATA  in  32  frame word.
- S_TVALID  in  1  word valid.
- S_TREADY  out  1  loader accepts a word.
- DATA  out  SIZE  active frame to the generator.
- AZ_IDX  out  clog2(AZ_COUNT)  azimuth index of the active frame.
- FRAME_SWAP  out  1  one-cycle pulse when a frame is swapped in.
- UNDERRUN  out  1  one-cycle pulse when TRIG finds the shadow buffer incomplete.
- UNDERRUN_STICKY  out  1  latched underrun; cleared only by reset or EN low.

Behaviour:
- Reset or EN=0: all outputs, DATA, shadow and AZ_IDX are 0; state FILL with word counter 0; S_TREADY=0.
- States:
  - FILL: S_TREADY=1. A transfer (S_TVALID & S_TREADY) writes S_TDATA to shadow bits [32*cnt+31:32*cnt]; the first word lands in bits [31:0]. cnt increments; on the transfer with cnt==WORDS-1, go to READY and reset cnt to 0.
  - READY: S_TREADY=0; wait for TRIG.
- TRIG in READY:
  - Next cycle DATA<=shadow, FRAME_SWAP=1, state->FILL.
- TRIG in FILL:
  - Underrun. Next cycle DATA<=0 (blank azimuth), UNDERRUN=1, UNDERRUN_STICKY=1.
  - The partial fill continues; words already loaded are kept and the frame completes normally.
- TRIG coinciding with the final word transfer in FILL:
  - Counts as success. DATA<=shadow with that word merged, FRAME_SWAP=1, state stays FILL with cnt=0.
- AZ_IDX:
  - Increments on every TRIG, whether swap or underrun, wrapping AZ_COUNT-1 -> 0.
  - ARP alone sets it to 0.
  - ARP and TRIG in the same cycle: AZ_IDX=0, and the TRIG is still serviced.
- Latency: TRIG at cycle n -> DATA/FRAME_SWAP/UNDERRUN/AZ_IDX valid at n+1.
- S_TREADY is registered; it deasserts the cycle after the final word transfer.
- TRIG while EN=0 is ignored.
- EN or RESETN deasserted mid-frame discards the partial shadow.

Optional Feature:
- Macro AZ_LOADER_STATS_EN.
- Defined:
  - Adds output UNDERRUN_CNT [15:0], which increments on each UNDERRUN pulse and saturates at 16'hFFFF.
  - Adds output FRAME_CNT [31:0], which increments on each FRAME_SWAP and wraps.
  - Both are cleared only by RESETN, not by EN.
- Undefined: neither port exists; no counter logic.

Decomposition:
- Shared package az_sim_pkg:
  - localparam AXIS_W=32.
  - Loader state enum {FILL, READY}.
  - Default SIZE=3200 and AZ_COUNT=4096.
  - Function words_of(size).
- One natural sub-module, az_shadow_buffer: indexed 32-bit word write into a SIZE-bit register, plus a full flag.
- The FSM, swap and azimuth counter stay in the top.

Test Plan:
- Fill 100 words of 32'hFFFF_FFFF, then pulse TRIG -> next cycle DATA all ones, FRAME_SWAP=1, AZ_IDX=1, S_TREADY=1.
- Fill 50 words, then pulse TRIG -> DATA=0, UNDERRUN=1, UNDERRUN_STICKY=1, AZ_IDX=1. Send the remaining 50 words and pulse TRIG -> FRAME_SWAP=1, DATA equals the full pattern.
- Final (100th) word transferred in the same cycle as TRIG -> FRAME_SWAP=1, DATA bits [3199:3168] equal that word, no UNDERRUN.
- 4095 successful TRIGs, then one more -> AZ_IDX wraps 4095->0. ARP with TRIG at AZ_IDX=10 -> AZ_IDX=0.
- Drop EN after 30 words -> S_TREADY=0 and DATA=0 within 1 cycle. Raise EN and send 100 words with word k = k -> DATA[31:0]=0, DATA[3199:3168]=99 after TRIG.
- With AZ_LOADER_STATS_EN: 3 underruns and 5 swaps -> UNDERRUN_CNT=3, FRAME_CNT=5. Toggling EN does not clear them.
